uart_word_assembler: RTL and testbench
======================================

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 Parameter: BYTES_PER_WORD, default 4, number of received bytes packed per output word (legal 2..8).
REQ-002 Parameter: TIMEOUT_TICKS, default 1600, baud ticks without a new byte before a partial word is discarded (10 byte times at 16 ticks/bit).
REQ-003 Port: clk  input  1  single clock; every register is clocked on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: baud_tick  input  1  one-clock pulse at 16x baud rate (307200 Hz), the same tick that drives the receiver.
REQ-006 Port: byte_valid  input  1  receiver data-valid level; stays high for up to one stop-bit period per byte.
REQ-007 Port: byte_in  input  8  received byte; stable while byte_valid is high.
REQ-008 Port: word_out  output  8*BYTES_PER_WORD  assembled word.
REQ-009 Port: word_valid  output  1  word_out holds an unconsumed word.
REQ-010 Port: word_ready  input  1  consumer accepts word_out when high together with word_valid.
REQ-011 Port: overrun  output  1  one-clock pulse: a completed word was dropped.
REQ-012 Port: timeout  output  1  one-clock pulse: a partial word was discarded.

Function
REQ-013 A byte event is a rising edge of byte_valid, detected as byte_valid=1 while its one-cycle registered copy is 0; exactly one event per received byte, regardless of level duration.
REQ-014 Byte order is LSB-first: the 1st byte of a word goes to word_out[7:0], the k-th byte to bits [8k-1:8k-8].
REQ-015 Collection FSM states: IDLE (0 bytes held) and COLLECT (1..BYTES_PER_WORD-1 bytes held).
REQ-016 IDLE + byte event -> COLLECT, byte_count=1; COLLECT + byte event -> byte_count+1; the event that completes the word -> IDLE, byte_count=0.
REQ-017 On word completion at clock edge k: if output register empty, or word_valid&word_ready in that same cycle, word_out loads the full word and word_valid is high from cycle k+1.
REQ-018 On word completion while word_valid=1 and word_ready=0: the new word is dropped, word_out/word_valid unchanged, overrun pulses for exactly one cycle.
REQ-019 word_valid&word_ready without completion: word_valid clears next cycle; word_out holds its last value.
REQ-020 Timeout counter: cleared on every byte event and in IDLE; increments on baud_tick in COLLECT; width ceil(log2(TIMEOUT_TICKS+1)), no wrap.
REQ-021 When the timeout counter reaches TIMEOUT_TICKS in COLLECT: partial bytes are discarded, FSM -> IDLE, timeout pulses for one cycle; output register is unaffected.
REQ-022 Byte event and timeout expiry in the same cycle: the byte event wins, the byte is stored, no timeout pulse.
REQ-023 Partial-word storage bits not yet written in the current word are don't-care internally but word_out always presents a fully written word.

Reset
REQ-024 rst=1 forces: FSM IDLE, byte_count 0, timeout counter 0, word_out 0, word_valid 0, overrun 0, timeout 0.
REQ-025 The byte_valid edge register resets to 1, so a byte_valid already high at reset release produces no byte event.
REQ-026 Reset mid-word or with a pending output word discards all contents with no overrun or timeout pulse.

Structure
REQ-027 Shared package rsa_uart_pkg holds BAUD_TICKS_PER_BIT (16), BITS_PER_FRAME (10) and DEFAULT_TIMEOUT_TICKS (1600).
REQ-028 One sub-module: rise_detect (1-bit rising-edge detector with parameterised reset value); the timeout counter and FSM stay inline.

Verification
REQ-029 Bytes 0x11,0x22,0x33,0x44, each with byte_valid high 16 ticks, word_ready=1 -> one word_valid with word_out=0x44332211, no overrun/timeout.
REQ-030 Word 0x44332211 pending with word_ready=0, then 0xAA,0xBB,0xCC,0xDD -> overrun pulse one cycle after 0xDD edge; word_out stays 0x44332211.
REQ-031 Bytes 0x01,0x02, then idle 1600 ticks -> timeout pulse; then 0x05,0x06,0x07,0x08 -> word_out=0x08070605.
REQ-032 Byte edge on the exact cycle the counter reaches 1600 -> no timeout; byte kept as 3rd byte of the word.
REQ-033 word_ready asserted in the completion cycle of 0xDDCCBBAA while 0x44332211 pending -> 0x44332211 consumed, 0xDDCCBBAA loaded, no overrun.
REQ-034 byte_valid held high across rst release, then rst asserted after 2 bytes -> no byte event at release; after reset word_valid=0 and next 4 bytes form a clean word.

Source files
------------

// File: rtl/rsa_uart_pkg.sv
// Shared UART framing constants and the word-assembler collection state type.
package rsa_uart_pkg;
  localparam int BAUD_TICKS_PER_BIT    = 16;
  localparam int BITS_PER_FRAME        = 10;
  // Ten byte times of silence abandon a partial word.
  localparam int DEFAULT_TIMEOUT_TICKS = BAUD_TICKS_PER_BIT * BITS_PER_FRAME * 10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;
endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector; the history flop resets to RESET_VAL so a level
// already high at reset release can be masked.
module rise_detect #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= RESET_VAL;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;
endmodule

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes LSB-first into BYTES_PER_WORD-byte words, with a
// one-deep output register, overrun reporting and an inter-byte timeout.
module uart_word_assembler
  import rsa_uart_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_TICKS  = DEFAULT_TIMEOUT_TICKS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_in,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overrun,
  output logic                        timeout
);
  localparam int WW = 8 * BYTES_PER_WORD;
  localparam int PW = 8 * (BYTES_PER_WORD - 1);
  localparam int CW = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_TICKS);

  asm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] part_q, part_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] word_q, word_d;
  logic          wv_q, wv_d;
  logic          ovr_q, ovr_d;
  logic          to_q, to_d;
  logic          byte_evt, complete, expire;

  // Edge history resets high: a byte_valid held across reset is not a new byte.
  rise_detect #(.RESET_VAL(1'b1)) u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (byte_valid),
    .rise (byte_evt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    part_d   = part_q;
    tmo_d    = tmo_q;
    word_d   = word_q;
    wv_d     = wv_q;
    ovr_d    = 1'b0;
    to_d     = 1'b0;
    complete = byte_evt && (cnt_q == LAST_IDX);
    expire   = (state_q == ST_COLLECT) && (tmo_q == TMO_MAX) && !byte_evt;

    if (byte_evt) begin
      tmo_d = '0;
      if (complete) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        part_d[8*cnt_q +: 8] = byte_in;
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_COLLECT;
      end
    end else if (expire) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      to_d    = 1'b1;
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (baud_tick && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + 1'b1;
    end

    // A completed word only lands if the register is free this cycle.
    if (complete) begin
      if (!wv_q || word_ready) begin
        word_d = {byte_in, part_q};
        wv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (wv_q && word_ready) begin
      wv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign overrun    = ovr_q;
  assign timeout    = to_q;
endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler; baud_tick is held high every clock so
// timeout runs stay short while keeping exact tick arithmetic.
module tb_uart_word_assembler;
  logic        clk = 1'b0;
  logic        rst;
  logic        baud_tick;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        overrun;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters fed by the monitor; tasks compare deltas against snapshots.
  int          hs_cnt  = 0;
  int          ovr_cnt = 0;
  int          tmo_cnt = 0;
  logic [31:0] last_word = '0;

  uart_word_assembler #(.BYTES_PER_WORD(4), .TIMEOUT_TICKS(1600)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) begin
        hs_cnt    <= hs_cnt + 1;
        last_word <= word_out;
      end
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (timeout) tmo_cnt <= tmo_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    repeat (16) tick();
    byte_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; word_ready = 1'b0; baud_tick = 1'b1;
    repeat (3) tick();
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid got=%0b want=0", word_valid); end
    n_checks++; if (word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word_out got=%h want=00000000", word_out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%0b want=0", timeout); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic_word();
    int hs0 = hs_cnt, ov0 = ovr_cnt, to0 = tmo_cnt;
    word_ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    n_checks++; if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL basic_handshakes got=%0d want=1", hs_cnt - hs0); end
    n_checks++; if (last_word !== 32'h44332211) begin n_fail++; $display("FAIL basic_word got=%h want=44332211", last_word); end
    n_checks++; if (ovr_cnt != ov0 || tmo_cnt != to0) begin n_fail++; $display("FAIL basic_no_pulses ovr=%0d tmo=%0d want=0,0", ovr_cnt - ov0, tmo_cnt - to0); end
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_cleared got=%0b want=0", word_valid); end
    n_checks++; if (word_out !== 32'h44332211) begin n_fail++; $display("FAIL basic_word_held got=%h want=44332211", word_out); end
  endtask

  task automatic test_overrun();
    int ov0;
    word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    n_checks++; if (word_valid !== 1'b1 || word_out !== 32'h44332211) begin n_fail++; $display("FAIL ovr_pending got=%0b/%h want=1/44332211", word_valid, word_out); end
    ov0 = ovr_cnt;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    byte_in = 8'hDD; byte_valid = 1'b1;
    tick();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got=%0b want=1", overrun); end
    tick();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_width got=%0b want=0", overrun); end
    repeat (14) tick();
    byte_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (ovr_cnt - ov0 !== 1) begin n_fail++; $display("FAIL ovr_count got=%0d want=1", ovr_cnt - ov0); end
    n_checks++; if (word_valid !== 1'b1 || word_out !== 32'h44332211) begin n_fail++; $display("FAIL ovr_word_kept got=%0b/%h want=1/44332211", word_valid, word_out); end
    word_ready = 1'b1; tick(); word_ready = 1'b0; tick();
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got=%0b want=0", word_valid); end
  endtask

  task automatic test_back_to_back();
    int ov0, hs0;
    word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    ov0 = ovr_cnt; hs0 = hs_cnt;
    byte_in = 8'hDD; byte_valid = 1'b1; word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    n_checks++; if (hs_cnt - hs0 !== 1 || last_word !== 32'h44332211) begin n_fail++; $display("FAIL b2b_consumed hs=%0d word=%h want=1/44332211", hs_cnt - hs0, last_word); end
    n_checks++; if (word_valid !== 1'b1 || word_out !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL b2b_loaded got=%0b/%h want=1/ddccbbaa", word_valid, word_out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun got=%0b want=0", overrun); end
    repeat (15) tick();
    byte_valid = 1'b0;
    word_ready = 1'b1; tick(); word_ready = 1'b0; repeat (3) tick();
    n_checks++; if (ovr_cnt != ov0 || last_word !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL b2b_drain ovr=%0d word=%h want=0/ddccbbaa", ovr_cnt - ov0, last_word); end
  endtask

  task automatic test_timeout();
    int hs0, to0;
    word_ready = 1'b1;
    to0 = tmo_cnt;
    send_byte(8'h01);
    byte_in = 8'h02; byte_valid = 1'b1;
    repeat (16) tick();
    byte_valid = 1'b0;
    repeat (1585) tick();
    // Counter reaches the limit 1601 edges after the raise; pulse one edge later.
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%0b want=0", timeout); end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got=%0b want=1", timeout); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width got=%0b want=0", timeout); end
    n_checks++; if (tmo_cnt - to0 !== 1) begin n_fail++; $display("FAIL tmo_count got=%0d want=1", tmo_cnt - to0); end
    hs0 = hs_cnt;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    n_checks++; if (hs_cnt - hs0 !== 1 || last_word !== 32'h08070605) begin n_fail++; $display("FAIL tmo_next_word hs=%0d word=%h want=1/08070605", hs_cnt - hs0, last_word); end
  endtask

  task automatic test_timeout_boundary();
    int hs0, to0;
    word_ready = 1'b1;
    to0 = tmo_cnt; hs0 = hs_cnt;
    send_byte(8'h01);
    byte_in = 8'h02; byte_valid = 1'b1;
    repeat (16) tick();
    byte_valid = 1'b0;
    repeat (1585) tick();
    // Counter sits at the limit now; this byte's edge lands on the expiry cycle.
    byte_in = 8'h03; byte_valid = 1'b1;
    repeat (16) tick();
    byte_valid = 1'b0;
    repeat (4) tick();
    send_byte(8'h04);
    n_checks++; if (tmo_cnt != to0) begin n_fail++; $display("FAIL bnd_no_timeout got=%0d want=0", tmo_cnt - to0); end
    n_checks++; if (hs_cnt - hs0 !== 1 || last_word !== 32'h04030201) begin n_fail++; $display("FAIL bnd_word hs=%0d word=%h want=1/04030201", hs_cnt - hs0, last_word); end
  endtask

  task automatic test_reset_release();
    int hs0, ov0, to0;
    word_ready = 1'b1;
    rst = 1'b1; byte_in = 8'h99; byte_valid = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    hs0 = hs_cnt;
    repeat (5) tick();
    byte_valid = 1'b0;
    repeat (3) tick();
    send_byte(8'h01); send_byte(8'h02);
    ov0 = ovr_cnt; to0 = tmo_cnt;
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (word_valid !== 1'b0 || word_out !== 32'h0) begin n_fail++; $display("FAIL rr_cleared got=%0b/%h want=0/00000000", word_valid, word_out); end
    rst = 1'b0;
    tick();
    n_checks++; if (overrun !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rr_no_pulses ovr=%0b tmo=%0b want=0,0", overrun, timeout); end
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    n_checks++; if (hs_cnt - hs0 !== 1 || last_word !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL rr_clean_word hs=%0d word=%h want=1/c4c3c2c1", hs_cnt - hs0, last_word); end
    n_checks++; if (ovr_cnt != ov0 || tmo_cnt != to0) begin n_fail++; $display("FAIL rr_counts ovr=%0d tmo=%0d want=0,0", ovr_cnt - ov0, tmo_cnt - to0); end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_reset_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
